// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the pipelined carry-lookahead adder.
//   CLA_BLK_W   : width of one lookahead block, and of one pipeline stage slice
//   CLA_MAX_W   : widest operand the adder supports
//   cla_nblk()  : number of blocks (and pipeline stages) for a given width
//   cla_stage_t : payload held in each stage register
package cla_pkg;

  localparam int CLA_BLK_W = 8;
  localparam int CLA_MAX_W = 64;

  function automatic int cla_nblk(input int width);
    return width / CLA_BLK_W;
  endfunction

  // a_rem/b_rem hold the operand bits not yet consumed, shifted down so the
  // next block always reads bits [7:0]. psum collects finished sum bytes in
  // their final bit positions. ovf is the overflow of the most recent block,
  // which is the MSB block once the payload reaches the last stage.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 ovf;
    logic [CLA_MAX_W-1:0] a_rem;
    logic [CLA_MAX_W-1:0] b_rem;
    logic [CLA_MAX_W-1:0] psum;
  } cla_stage_t;

endpackage

// File: rtl/cla_block8.sv
// cla_block8: purely combinational 8-bit carry-lookahead slice.
//   a, b   : 8-bit operand slices
//   ci     : carry into bit 0 of the slice
//   s      : 8-bit sum slice
//   co     : carry out of bit 7
//   ci_msb : carry into bit 7 (overflow detection when this is the top slice)
module cla_block8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co,
  output logic       ci_msb
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       prop;

  // Each carry is built directly from generate/propagate terms:
  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, so no carry waits on another.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    prop = 1'b0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      prop   = p[i];
      c[i+1] = g[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & ci);
    end
    s      = p ^ c[7:0];
    co     = c[8];
    ci_msb = c[7];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder/subtractor built from WIDTH/8 lookahead
// blocks, one block per pipeline stage, with a valid/ready handshake.
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready does not look at in_valid)
//   a, b, sub, cin      : operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready : result handshake
//   sum, cout           : result and carry out of the MSB (sub: 1 = no borrow)
//   ovf                 : signed overflow, only when CLA_OVF_EN is defined
// Build option: define CLA_OVF_EN to add the ovf port.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int NBLK = cla_nblk(WIDTH);

  if ((WIDTH % CLA_BLK_W) != 0 || WIDTH < CLA_BLK_W || WIDTH > CLA_MAX_W) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of 8 between 8 and 64");
  end

  cla_stage_t st_q [NBLK];
  cla_stage_t st_d [NBLK];
  cla_stage_t src  [NBLK];

  logic [NBLK-1:0][7:0] blk_a;
  logic [NBLK-1:0][7:0] blk_b;
  logic [NBLK-1:0][7:0] blk_s;
  logic [NBLK-1:0]      blk_ci;
  logic [NBLK-1:0]      blk_co;
  logic [NBLK-1:0]      blk_cmsb;

  logic [CLA_MAX_W-1:0] a_ext;
  logic [CLA_MAX_W-1:0] b_ext;
  logic                 adv;

  // The whole chain moves together whenever the output slot is free or being
  // drained; bubbles move along with it rather than being squeezed out.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Stage 0 takes the live operands (b already inverted for subtract, with the
  // +1 supplied as carry-in); every later stage takes its predecessor register.
  always_comb begin
    a_ext              = '0;
    b_ext              = '0;
    a_ext[WIDTH-1:0]   = a;
    b_ext[WIDTH-1:0]   = sub ? ~b : b;
    src[0]             = '0;
    src[0].valid       = in_valid;
    src[0].carry       = sub ? 1'b1 : cin;
    src[0].a_rem       = a_ext;
    src[0].b_rem       = b_ext;
    for (int k = 1; k < NBLK; k++) begin
      src[k] = st_q[k-1];
    end
  end

  always_comb begin
    blk_a  = '0;
    blk_b  = '0;
    blk_ci = '0;
    for (int k = 0; k < NBLK; k++) begin
      blk_a[k]  = src[k].a_rem[CLA_BLK_W-1:0];
      blk_b[k]  = src[k].b_rem[CLA_BLK_W-1:0];
      blk_ci[k] = src[k].carry;
    end
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    cla_block8 u_blk (
      .a      (blk_a[k]),
      .b      (blk_b[k]),
      .ci     (blk_ci[k]),
      .s      (blk_s[k]),
      .co     (blk_co[k]),
      .ci_msb (blk_cmsb[k])
    );
  end

  // Each stage drops the byte it consumed from the operand remainders and
  // drops its finished sum byte into place, so the result is aligned on exit.
  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      st_d[k]       = src[k];
      st_d[k].carry = blk_co[k];
      st_d[k].a_rem = src[k].a_rem >> CLA_BLK_W;
      st_d[k].b_rem = src[k].b_rem >> CLA_BLK_W;
      st_d[k].psum  = src[k].psum |
                      ({{(CLA_MAX_W-CLA_BLK_W){1'b0}}, blk_s[k]} << (CLA_BLK_W * k));
`ifdef CLA_OVF_EN
      st_d[k].ovf   = blk_cmsb[k] ^ blk_co[k];
`else
      st_d[k].ovf   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NBLK; k++) begin
        st_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NBLK; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign out_valid = st_q[NBLK-1].valid;
  assign sum       = st_q[NBLK-1].psum[WIDTH-1:0];
  assign cout      = st_q[NBLK-1].carry;

`ifdef CLA_OVF_EN
  assign ovf = st_q[NBLK-1].ovf;
`endif

  // The last stage's remainders are always empty and the per-block carry into
  // bit 7 only matters on the top block; collect them so nothing dangles.
  logic unused_tail;
  assign unused_tail = ^{st_q[NBLK-1], blk_cmsb};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
`ifdef CLA_OVF_EN
  logic        ovf;
`endif

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        sub8;
  logic        cin8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  sum8;
  logic        cout8;
`ifdef CLA_OVF_EN
  logic        ovf8;
`endif

  int checks;
  int errors;

  pipelined_cla_adder #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CLA_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  pipelined_cla_adder #(.WIDTH(8)) dut8 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .sub       (sub8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
`ifdef CLA_OVF_EN
    .cout      (cout8),
    .ovf       (ovf8)
`else
    .cout      (cout8)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Independent reference: full-width add with explicit inversion for subtract.
  function automatic logic [33:0] refModel(input logic [31:0] ma, input logic [31:0] mb,
                                           input logic ms, input logic mc);
    logic [31:0] be;
    logic [32:0] r;
    logic        ov;
    be = ms ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + {32'b0, (ms ? 1'b1 : mc)};
    ov = (ma[31] == be[31]) && (r[31] != ma[31]);
    return {ov, r};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ta, input logic [31:0] tbv,
                               input logic ts, input logic tc);
    in_valid = v;
    a        = ta;
    b        = tbv;
    sub      = ts;
    cin      = tc;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One isolated transaction: checks the NBLK-cycle latency and the result.
  task automatic singleTxn(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                           input logic ts, input logic tc, input logic [31:0] esum,
                           input logic ecout, input logic eovf);
    applyStimulus(1'b1, ta, tbv, ts, tc);
    #1;
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("%s_early%0d", tag, i), out_valid, 0);
      step();
    end
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_sum"}, sum, esum);
    checkOutput({tag, "_cout"}, cout, ecout);
`ifdef CLA_OVF_EN
    checkOutput({tag, "_ovf"}, ovf, eovf);
`else
    begin
      logic unused_eovf;
      unused_eovf = eovf;
    end
`endif
    step();
    checkOutput({tag, "_drain"}, out_valid, 0);
  endtask

  logic [31:0] sa [10];
  logic [31:0] sb [10];
  logic        ss [10];
  logic        sc [10];
  logic [33:0] expq [$];
  logic [33:0] exp_r;
  logic        stall;
  int          acc;
  int          got;
  int          cyc;

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    out_ready  = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    in_valid8  = 1'b0;
    a8         = 8'h00;
    b8         = 8'h00;
    sub8       = 1'b0;
    cin8       = 1'b0;
    out_ready8 = 1'b1;

    // Reset state
    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_w8_out_valid", out_valid8, 0);
    step();
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    step();

    // Directed single transactions, expected values worked by hand
    singleTxn("carry_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    singleTxn("sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    singleTxn("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    singleTxn("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    singleTxn("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    singleTxn("add_cin",    32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
    singleTxn("sub_cin_ign",32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // Back-to-back stream with the consumer stalled in cycles 6-8
    for (int i = 0; i < 10; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      ss[i] = 1'($urandom_range(0, 1));
      sc[i] = 1'($urandom_range(0, 1));
    end
    acc = 0;
    got = 0;
    cyc = 0;
    while (got < 10 && cyc < 60) begin
      stall     = (cyc >= 6 && cyc <= 8);
      out_ready = !stall;
      if (acc < 10) applyStimulus(1'b1, sa[acc], sb[acc], ss[acc], sc[acc]);
      else          applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("stream_in_ready_c%0d", cyc), in_ready, {63'b0, !stall});
      if (out_valid) begin
        if (expq.size() == 0) begin
          checkOutput($sformatf("stream_unexpected_c%0d", cyc), out_valid, 0);
        end else begin
          exp_r = expq[0];
          checkOutput($sformatf("stream_sum_c%0d", cyc), sum, exp_r[31:0]);
          checkOutput($sformatf("stream_cout_c%0d", cyc), cout, exp_r[32]);
`ifdef CLA_OVF_EN
          checkOutput($sformatf("stream_ovf_c%0d", cyc), ovf, exp_r[33]);
`endif
          if (out_ready) begin
            void'(expq.pop_front());
            got++;
          end
        end
      end
      if (acc < 10 && !stall) begin
        expq.push_back(refModel(sa[acc], sb[acc], ss[acc], sc[acc]));
        acc++;
      end
      step();
      cyc++;
    end
    checkOutput("stream_count", got, 10);
    checkOutput("stream_leftover", expq.size(), 0);
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (5) step();

    // Reset pulse with three operand sets in flight, the oldest at the output
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0000_1000 + i, 32'h0000_0001, 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("rstmid_pre_valid", out_valid, 1);
    checkOutput("rstmid_pre_sum", sum, 32'h0000_1001);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstmid_out_valid", out_valid, 0);
    checkOutput("rstmid_sum", sum, 0);
    checkOutput("rstmid_cout", cout, 0);
`ifdef CLA_OVF_EN
    checkOutput("rstmid_ovf", ovf, 0);
`endif
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    #1;
    checkOutput("rstmid_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput($sformatf("rstmid_no_stale_%0d", i), out_valid, 0);
    end

    // Single-block build: one cycle of latency
    in_valid8 = 1'b1;
    a8        = 8'h80;
    b8        = 8'h80;
    sub8      = 1'b0;
    cin8      = 1'b1;
    #1;
    checkOutput("w8_in_ready", in_ready8, 1);
    checkOutput("w8_pre_valid", out_valid8, 0);
    step();
    in_valid8 = 1'b0;
    checkOutput("w8_valid", out_valid8, 1);
    checkOutput("w8_sum", sum8, 8'h01);
    checkOutput("w8_cout", cout8, 1);
`ifdef CLA_OVF_EN
    checkOutput("w8_ovf", ovf8, 1);
`endif
    step();
    checkOutput("w8_drain", out_valid8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
